proc_alu_share_arb: RTL and testbench

Two-port round-robin arbiter that time-shares one combinational ALU (32-bit, 4-bit function code, eq/lt/ltu flags) between two val/rdy requesters, e.g. the X-stage pipeline and an iterative mul/div unit. Each cycle it grants at most one request, steers that request's operands and function onto the shared ALU, and captures the result into that requester's one-entry response buffer. Responses return on per-requester val/rdy ports one cycle after grant.

---
 rtl/proc_alu_share_arb.sv | 129 ++++++++++++
 tb/tb_proc_alu_share_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_alu_share_arb.sv
// Round-robin arbiter time-sharing one combinational ALU between two val/rdy
// requesters. Each granted request's ALU result and comparison flags are
// captured into that requester's one-entry response buffer for the next cycle.
module proc_alu_share_arb #(
  parameter int unsigned PNbits = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // requester 0
  input  logic              req0_val_i,
  output logic              req0_rdy_o,
  input  logic [PNbits-1:0] req0_in0_i,
  input  logic [PNbits-1:0] req0_in1_i,
  input  logic [3:0]        req0_fn_i,
  // requester 1
  input  logic              req1_val_i,
  output logic              req1_rdy_o,
  input  logic [PNbits-1:0] req1_in0_i,
  input  logic [PNbits-1:0] req1_in1_i,
  input  logic [3:0]        req1_fn_i,
  // response 0
  output logic              resp0_val_o,
  input  logic              resp0_rdy_i,
  output logic [PNbits-1:0] resp0_out_o,
  output logic              resp0_eq_o,
  output logic              resp0_lt_o,
  output logic              resp0_ltu_o,
  // response 1
  output logic              resp1_val_o,
  input  logic              resp1_rdy_i,
  output logic [PNbits-1:0] resp1_out_o,
  output logic              resp1_eq_o,
  output logic              resp1_lt_o,
  output logic              resp1_ltu_o,
  // shared ALU
  output logic [PNbits-1:0] alu_in0_o,
  output logic [PNbits-1:0] alu_in1_o,
  output logic [3:0]        alu_fn_o,
  input  logic [PNbits-1:0] alu_out_i,
  input  logic              alu_ops_eq_i,
  input  logic              alu_ops_lt_i,
  input  logic              alu_ops_ltu_i
);

  localparam int unsigned PayW = PNbits + 3;

  logic            prio_q, prio_d;
  logic [1:0]      buf_v_q, buf_v_d;
  logic [PayW-1:0] buf0_q, buf0_d;
  logic [PayW-1:0] buf1_q, buf1_d;
  logic [1:0]      elig;
  logic [1:0]      gnt;
  logic [PayW-1:0] alu_pay;

  // Eligibility and grant; a full buffer may be refilled while it drains.
  always_comb begin
    elig[0] = req0_val_i & (~buf_v_q[0] | resp0_rdy_i);
    elig[1] = req1_val_i & (~buf_v_q[1] | resp1_rdy_i);
    gnt[0]  = ~reset_i & elig[0] & (~elig[1] | ~prio_q);
    gnt[1]  = ~reset_i & elig[1] & (~elig[0] |  prio_q);
  end

  assign req0_rdy_o = gnt[0];
  assign req1_rdy_o = gnt[1];

  // Steer the granted request onto the ALU; idle drives zeros.
  always_comb begin
    alu_in0_o = '0;
    alu_in1_o = '0;
    alu_fn_o  = '0;
    if (gnt[0]) begin
      alu_in0_o = req0_in0_i;
      alu_in1_o = req0_in1_i;
      alu_fn_o  = req0_fn_i;
    end else if (gnt[1]) begin
      alu_in0_o = req1_in0_i;
      alu_in1_o = req1_in1_i;
      alu_fn_o  = req1_fn_i;
    end
  end

  assign alu_pay = {alu_out_i, alu_ops_eq_i, alu_ops_lt_i, alu_ops_ltu_i};

  // Next-state for priority and response buffers.
  always_comb begin
    prio_d  = prio_q;
    buf_v_d = buf_v_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (gnt[0]) begin
      buf_v_d[0] = 1'b1;
      buf0_d     = alu_pay;
      prio_d     = 1'b1;
    end else if (buf_v_q[0] && resp0_rdy_i) begin
      buf_v_d[0] = 1'b0;
    end
    if (gnt[1]) begin
      buf_v_d[1] = 1'b1;
      buf1_d     = alu_pay;
      prio_d     = 1'b0;
    end else if (buf_v_q[1] && resp1_rdy_i) begin
      buf_v_d[1] = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_q  <= 1'b0;
      buf_v_q <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      prio_q  <= prio_d;
      buf_v_q <= buf_v_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  // Responses are forced quiet while reset is held.
  always_comb begin
    resp0_val_o = buf_v_q[0] & ~reset_i;
    resp1_val_o = buf_v_q[1] & ~reset_i;
    {resp0_out_o, resp0_eq_o, resp0_lt_o, resp0_ltu_o} = reset_i ? '0 : buf0_q;
    {resp1_out_o, resp1_eq_o, resp1_lt_o, resp1_ltu_o} = reset_i ? '0 : buf1_q;
  end

endmodule

// File: tb/tb_proc_alu_share_arb.sv
// Self-checking bench: behavioural ALU on the shared port, a rule-level model
// of grants and response buffers, table vectors, corner sequences, random run.
module tb_proc_alu_share_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        r_val [2];
  logic        r_rdy [2];
  logic [31:0] r_in0 [2];
  logic [31:0] r_in1 [2];
  logic [3:0]  r_fn  [2];

  logic        req0_rdy, req1_rdy;
  logic        resp0_val, resp1_val;
  logic [31:0] resp0_out, resp1_out;
  logic        resp0_eq, resp0_lt, resp0_ltu, resp1_eq, resp1_lt, resp1_ltu;
  logic [31:0] alu_in0, alu_in1, alu_out;
  logic [3:0]  alu_fn;
  logic        alu_eq, alu_lt, alu_ltu;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Reference ALU: {result, eq, lt, ltu}
  function automatic logic [34:0] alu_full(input logic [3:0] fn, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (fn)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << b[4:0];
      4'd3:    r = a | b;
      4'd4:    r = {31'd0, $signed(a) < $signed(b)};
      4'd5:    r = {31'd0, a < b};
      4'd6:    r = a & b;
      4'd7:    r = a ^ b;
      4'd8:    r = ~(a | b);
      4'd9:    r = a >> b[4:0];
      4'd10:   r = $signed(a) >>> b[4:0];
      4'd11:   r = a;
      4'd12:   r = b;
      4'd13:   r = (a + b) & 32'hFFFF_FFFE;
      default: r = 32'd0;
    endcase
    return {r, a == b, $signed(a) < $signed(b), a < b};
  endfunction

  always_comb {alu_out, alu_eq, alu_lt, alu_ltu} = alu_full(alu_fn, alu_in0, alu_in1);

  proc_alu_share_arb #(.PNbits(32)) dut (
    .clk_i(clk), .reset_i(reset),
    .req0_val_i(r_val[0]), .req0_rdy_o(req0_rdy), .req0_in0_i(r_in0[0]),
    .req0_in1_i(r_in1[0]), .req0_fn_i(r_fn[0]),
    .req1_val_i(r_val[1]), .req1_rdy_o(req1_rdy), .req1_in0_i(r_in0[1]),
    .req1_in1_i(r_in1[1]), .req1_fn_i(r_fn[1]),
    .resp0_val_o(resp0_val), .resp0_rdy_i(r_rdy[0]), .resp0_out_o(resp0_out),
    .resp0_eq_o(resp0_eq), .resp0_lt_o(resp0_lt), .resp0_ltu_o(resp0_ltu),
    .resp1_val_o(resp1_val), .resp1_rdy_i(r_rdy[1]), .resp1_out_o(resp1_out),
    .resp1_eq_o(resp1_eq), .resp1_lt_o(resp1_lt), .resp1_ltu_o(resp1_ltu),
    .alu_in0_o(alu_in0), .alu_in1_o(alu_in1), .alu_fn_o(alu_fn),
    .alu_out_i(alu_out), .alu_ops_eq_i(alu_eq), .alu_ops_lt_i(alu_lt),
    .alu_ops_ltu_i(alu_ltu)
  );

  // Model state: favoured requester and per-requester buffered response
  int          m_prio;
  bit          m_v   [2];
  logic [34:0] m_pay [2];

  // Values sampled from the DUT in the last step
  logic [1:0]  s_gnt;
  logic [1:0]  s_val;
  logic [34:0] s_pay [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // One cycle: inputs already applied just after the previous edge.
  task automatic step();
    int          g;
    bit          el [2];
    logic [31:0] e_in0, e_in1;
    logic [3:0]  e_fn;
    #3;
    g = -1;
    if (!reset) begin
      for (int i = 0; i < 2; i++) el[i] = r_val[i] && (!m_v[i] || r_rdy[i]);
      if (el[0] && el[1]) g = m_prio;
      else if (el[0])     g = 0;
      else if (el[1])     g = 1;
    end
    e_in0 = (g >= 0) ? r_in0[g] : 32'd0;
    e_in1 = (g >= 0) ? r_in1[g] : 32'd0;
    e_fn  = (g >= 0) ? r_fn[g]  : 4'd0;
    s_gnt    = {req1_rdy, req0_rdy};
    s_val    = {resp1_val, resp0_val};
    s_pay[0] = {resp0_out, resp0_eq, resp0_lt, resp0_ltu};
    s_pay[1] = {resp1_out, resp1_eq, resp1_lt, resp1_ltu};
    chk("req_rdy", 64'(s_gnt), {62'd0, g == 1, g == 0});
    chk("alu_in0", 64'(alu_in0), 64'(e_in0));
    chk("alu_in1", 64'(alu_in1), 64'(e_in1));
    chk("alu_fn", 64'(alu_fn), 64'(e_fn));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("resp%0d_val", i), 64'(s_val[i]), 64'(m_v[i] && !reset));
      chk($sformatf("resp%0d_payload", i), 64'(s_pay[i]), reset ? 64'd0 : 64'(m_pay[i]));
    end
    @(posedge clk);
    if (reset) begin
      m_prio = 0;
      for (int i = 0; i < 2; i++) begin m_v[i] = 0; m_pay[i] = '0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (g == i) begin
          m_v[i]   = 1;
          m_pay[i] = alu_full(r_fn[i], r_in0[i], r_in1[i]);
        end else if (m_v[i] && r_rdy[i]) begin
          m_v[i] = 0;
        end
      end
      if (g >= 0) m_prio = 1 - g;
    end
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [3:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
    r_val[i] = v; r_fn[i] = fn; r_in0[i] = a; r_in1[i] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  fn;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] out;
    logic        eq, lt, ltu;
  } vec_t;

  vec_t        vecs [10];
  logic [34:0] held;
  logic [34:0] want;

  initial begin
    vecs[0] = '{4'd1,  32'd7,          32'd5, 32'd2,          1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'd0,  32'd3,          32'd4, 32'd7,          1'b0, 1'b1, 1'b1};
    vecs[2] = '{4'd2,  32'd1,          32'd4, 32'd16,         1'b0, 1'b1, 1'b1};
    vecs[3] = '{4'd4,  32'hFFFF_FFFF,  32'd1, 32'd1,          1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'd5,  32'hFFFF_FFFF,  32'd1, 32'd0,          1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'd10, 32'h8000_0000,  32'd4, 32'hF800_0000,  1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'd13, 32'h0000_1001,  32'd2, 32'h0000_1002,  1'b0, 1'b0, 1'b0};
    vecs[7] = '{4'd9,  32'h8000_0000,  32'd4, 32'h0800_0000,  1'b0, 1'b1, 1'b0};
    vecs[8] = '{4'd14, 32'd5,          32'd5, 32'd0,          1'b1, 1'b0, 1'b0};
    vecs[9] = '{4'd12, 32'd5,          32'd9, 32'd9,          1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin set_req(i, 0, 4'd0, 32'd0, 32'd0); r_rdy[i] = 1'b1; end
    m_prio = 0;
    for (int i = 0; i < 2; i++) begin m_v[i] = 0; m_pay[i] = '0; end
    @(posedge clk); #1;
    do_reset();
    chk("reset_quiet", 64'({s_gnt, s_val}), 64'd0);

    // Single-requester vectors
    foreach (vecs[k]) begin
      set_req(0, 1, vecs[k].fn, vecs[k].in0, vecs[k].in1);
      step();
      chk($sformatf("vec%0d_rdy", k), 64'(s_gnt), 64'd1);
      set_req(0, 0, 4'd0, 32'd0, 32'd0);
      step();
      chk($sformatf("vec%0d_resp", k), 64'({s_val[0], s_pay[0]}),
          64'({1'b1, vecs[k].out, vecs[k].eq, vecs[k].lt, vecs[k].ltu}));
    end

    // Conflict: alternate grants starting with requester 0
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 2; i++) set_req(i, 1, 4'($urandom_range(0, 13)), $urandom, $urandom);
      step();
      chk($sformatf("conflict%0d_gnt", c), 64'(s_gnt), (c % 2 == 0) ? 64'd1 : 64'd2);
    end

    // Backpressure on requester 0; requester 1 keeps the slot
    do_reset();
    r_rdy[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 2; i++) set_req(i, 1, 4'd0, $urandom, $urandom);
      step();
      chk($sformatf("bp%0d_gnt", c), 64'(s_gnt), (c == 0) ? 64'd1 : 64'd2);
      if (c == 1) held = s_pay[0];
      if (c > 1) chk($sformatf("bp%0d_hold", c), 64'({s_val[0], s_pay[0]}), 64'({1'b1, held}));
    end

    // Pass-through: drain and refill requester 0 in the same cycle
    r_rdy[0] = 1'b1;
    set_req(0, 1, 4'd7, 32'h1234_5678, 32'h0F0F_0F0F);
    want = {32'h1D3B_5977, 1'b0, 1'b0, 1'b0};
    step();
    chk("pass_gnt", 64'(s_gnt), 64'd1);
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    set_req(1, 0, 4'd0, 32'd0, 32'd0);
    step();
    chk("pass_resp", 64'({s_val[0], s_pay[0]}), 64'({1'b1, want}));

    // Idle: ALU quiet, priority (now favouring 1) kept
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_alu", 64'({alu_in0, alu_in1, alu_fn}), 64'd0);
    end
    for (int i = 0; i < 2; i++) set_req(i, 1, 4'd0, $urandom, $urandom);
    step();
    chk("idle_prio_gnt", 64'(s_gnt), 64'd2);

    // Reset mid-flight with both buffers full
    r_rdy[0] = 1'b0; r_rdy[1] = 1'b0;
    step(); step();
    do_reset();
    for (int i = 0; i < 2; i++) set_req(i, 0, 4'd0, 32'd0, 32'd0);
    step();
    chk("post_reset_val", 64'(s_val), 64'd0);
    r_rdy[0] = 1'b1; r_rdy[1] = 1'b1;
    for (int i = 0; i < 2; i++) set_req(i, 1, 4'd1, $urandom, $urandom);
    step();
    chk("post_reset_gnt", 64'(s_gnt), 64'd1);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 2; i++) begin
        set_req(i, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, $urandom);
        r_rdy[i] = $urandom_range(0, 2) != 0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
